multicycle_controller: RTL

- Multi-cycle control FSM for the RV32I core; sequences instruction fetch, decode, ALU execute, data-memory access and register writeback.
- Drives the ALU's alu_op/alu_src controls, the PC/IR/register-file write enables and both memory request handshakes.
- Consumes the ALU's do_branch result.
- Sits between the instruction register/opcode field and the shared datapath; one instruction in flight at a time.

---
 rtl/multicycle_controller_pkg.sv | 65 ++++++
 rtl/multicycle_controller_ctrl_decode.sv | 80 ++++++++
 rtl/multicycle_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the RV32I multi-cycle control FSM: opcode constants, ALU control
// encodings, PC/writeback select encodings, FSM states and instruction classes.
package multicycle_controller_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OpcR      = 7'h33;
  localparam logic [6:0] OpcI      = 7'h13;
  localparam logic [6:0] OpcLoad   = 7'h03;
  localparam logic [6:0] OpcStore  = 7'h23;
  localparam logic [6:0] OpcBranch = 7'h63;
  localparam logic [6:0] OpcJal    = 7'h6F;
  localparam logic [6:0] OpcJalr   = 7'h67;
  localparam logic [6:0] OpcLui    = 7'h37;
  localparam logic [6:0] OpcAuipc  = 7'h17;
  localparam logic [6:0] OpcSystem = 7'h73;

  // ALU operation classes
  localparam logic [3:0] AluOpReg    = 4'd0;
  localparam logic [3:0] AluOpImm    = 4'd1;
  localparam logic [3:0] AluOpAdd    = 4'd2;
  localparam logic [3:0] AluOpBranch = 4'd3;
  localparam logic [3:0] AluOpJal    = 4'd4;
  localparam logic [3:0] AluOpJalr   = 4'd5;
  localparam logic [3:0] AluOpLui    = 4'd6;

  // ALU operand selects: bit0 = A is pc, bit1 = B is imm
  localparam logic [1:0] AluSrcRegs = 2'b00;
  localparam logic [1:0] AluSrcAPc  = 2'b01;
  localparam logic [1:0] AluSrcBImm = 2'b10;

  // Next-PC selects
  localparam logic [1:0] PcSrcSeq    = 2'd0;  // pc + 4
  localparam logic [1:0] PcSrcPcImm  = 2'd1;  // pc + imm
  localparam logic [1:0] PcSrcRegImm = 2'd2;  // rs1 + imm

  // Register writeback selects
  localparam logic WbSelAlu  = 1'b0;
  localparam logic WbSelLoad = 1'b1;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt,
    StTrap
  } state_e;

  typedef enum logic [3:0] {
    ClsR,
    ClsI,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJal,
    ClsJalr,
    ClsLui,
    ClsAuipc,
    ClsSystem,
    ClsIllegal
  } cls_e;

endpackage

// File: rtl/multicycle_controller_ctrl_decode.sv
`timescale 1ns/1ps
// Combinational opcode decoder.
// Ports:
//   opcode    in   instr[6:0]
//   cls       out  instruction class
//   alu_op    out  ALU operation class for the instruction
//   alu_src   out  ALU operand selects for the instruction
//   illegal   out  opcode is not supported
//   is_system out  ecall/ebreak
module ctrl_decode
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_e       cls,
  output logic [3:0] alu_op,
  output logic [1:0] alu_src,
  output logic       illegal,
  output logic       is_system
);

  always_comb begin
    cls       = ClsIllegal;
    alu_op    = AluOpReg;
    alu_src   = AluSrcRegs;
    illegal   = 1'b0;
    is_system = 1'b0;
    unique case (opcode)
      OpcR: begin
        cls = ClsR;
      end
      OpcI: begin
        cls     = ClsI;
        alu_op  = AluOpImm;
        alu_src = AluSrcBImm;
      end
      OpcLoad: begin
        cls     = ClsLoad;
        alu_op  = AluOpAdd;
        alu_src = AluSrcBImm;
      end
      OpcStore: begin
        cls     = ClsStore;
        alu_op  = AluOpAdd;
        alu_src = AluSrcBImm;
      end
      OpcBranch: begin
        cls    = ClsBranch;
        alu_op = AluOpBranch;
      end
      OpcJal: begin
        cls     = ClsJal;
        alu_op  = AluOpJal;
        alu_src = AluSrcAPc;
      end
      OpcJalr: begin
        cls     = ClsJalr;
        alu_op  = AluOpJalr;
        alu_src = AluSrcAPc;
      end
      OpcLui: begin
        cls     = ClsLui;
        alu_op  = AluOpLui;
        alu_src = AluSrcBImm;
      end
      OpcAuipc: begin
        cls     = ClsAuipc;
        alu_op  = AluOpAdd;
        alu_src = AluSrcAPc | AluSrcBImm;
      end
      OpcSystem: begin
        cls       = ClsSystem;
        is_system = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
`timescale 1ns/1ps
// Multi-cycle control FSM for the RV32I core: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// One instruction in flight; HALT (ecall/ebreak) and TRAP (illegal opcode or memory
// timeout) are absorbing until reset.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   opcode, do_branch    IR opcode field and ALU branch result
//   imem_req/imem_ack    instruction fetch handshake; ir_we latches IR on ack
//   dmem_req/we/ack      data access handshake
//   pc_we, pc_src        PC update and next-PC select
//   alu_op, alu_src      ALU controls, stable through EXEC/MEM/WB
//   reg_we, wb_sel       register writeback
//   halt, trap           sticky status
//   instret              retired-instruction counter
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        do_branch,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_src,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        halt,
  output logic        trap,
  output logic [31:0] instret
);

  // Last counter value before a request without ack traps.
  localparam logic [TO_W-1:0] ToLast = TO_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [1:0]        alu_src_q, alu_src_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [31:0]       instret_q, instret_d;
  // Low during reset and the reset-release cycle; keeps every output quiet until the first
  // clock edge after release so nothing pulses while reset is being removed.
  logic              live_q;

  cls_e       dec_cls;
  logic [3:0] dec_alu_op;
  logic [1:0] dec_alu_src;
  logic       dec_illegal;
  logic       dec_system;

  ctrl_decode u_decode (
    .opcode    (opcode),
    .cls       (dec_cls),
    .alu_op    (dec_alu_op),
    .alu_src   (dec_alu_src),
    .illegal   (dec_illegal),
    .is_system (dec_system)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cls_q     <= ClsR;
      alu_op_q  <= '0;
      alu_src_q <= '0;
      cnt_q     <= '0;
      instret_q <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      alu_op_q  <= alu_op_d;
      alu_src_q <= alu_src_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
      live_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    alu_op_d  = alu_op_q;
    alu_src_d = alu_src_q;
    cnt_d     = '0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PcSrcSeq;
    alu_op    = '0;
    alu_src   = '0;
    reg_we    = 1'b0;
    wb_sel    = WbSelAlu;
    halt      = 1'b0;
    trap      = 1'b0;

    if (live_q) begin
      unique case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we   = 1'b1;
            state_d = StDecode;
          end else if (cnt_q == ToLast) begin
            state_d = StTrap;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
        StDecode: begin
          if (dec_system) begin
            state_d = StHalt;
          end else if (dec_illegal) begin
            state_d = StTrap;
          end else begin
            cls_d     = dec_cls;
            alu_op_d  = dec_alu_op;
            alu_src_d = dec_alu_src;
            state_d   = StExec;
          end
        end
        StExec: begin
          alu_op  = alu_op_q;
          alu_src = alu_src_q;
          case (cls_q)
            ClsLoad, ClsStore: state_d = StMem;
            ClsBranch: begin
              pc_we   = 1'b1;
              pc_src  = do_branch ? PcSrcPcImm : PcSrcSeq;
              state_d = StFetch;
            end
            default: state_d = StWb;
          endcase
        end
        StMem: begin
          alu_op   = alu_op_q;
          alu_src  = alu_src_q;
          dmem_req = 1'b1;
          dmem_we  = (cls_q == ClsStore);
          if (dmem_ack) begin
            if (cls_q == ClsStore) begin
              pc_we   = 1'b1;
              state_d = StFetch;
            end else begin
              state_d = StWb;
            end
          end else if (cnt_q == ToLast) begin
            state_d = StTrap;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
        StWb: begin
          alu_op  = alu_op_q;
          alu_src = alu_src_q;
          reg_we  = 1'b1;
          pc_we   = 1'b1;
          wb_sel  = (cls_q == ClsLoad) ? WbSelLoad : WbSelAlu;
          if (cls_q == ClsJal) begin
            pc_src = PcSrcPcImm;
          end else if (cls_q == ClsJalr) begin
            pc_src = PcSrcRegImm;
          end
          state_d = StFetch;
        end
        StHalt: halt = 1'b1;
        StTrap: trap = 1'b1;
        default: state_d = StTrap;
      endcase
    end

    // One pc_we pulse per retired instruction, so it doubles as the retire strobe.
    instret_d = instret_q + 32'(pc_we);
  end

  assign instret = instret_q;

endmodule
